truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Self-checking exhaustive stimulus engine for combinational lab blocks of up to N_IN inputs and N_OUT outputs.
- Drives every input vector 0 .. 2^N_IN-1 in ascending binary order and holds each vector for HOLD_CYCLES clocks.
- Samples the DUT output once per vector and compares it against a parameterised truth table.
- Reports the mismatch count, the first failing vector, and a pass flag. It replaces fixed-delay hand-written sweeps with a synthesizable, clocked sweeper usable on board or in simulation.

Parameters:
- N_IN, 4, number of DUT inputs (1..8).
- N_OUT, 1, number of DUT outputs (1..8).
- HOLD_CYCLES, 50, clocks each vector is driven (>=2).
- SAMPLE_AT, 1, hold-cycle index at which dut_out is sampled (0 < SAMPLE_AT < HOLD_CYCLES).
- EXPECTED, all zeros, truth table of width (2^N_IN)*N_OUT. Entry for vector v is EXPECTED[v*N_OUT +: N_OUT].

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse that begins a sweep.
- stop_on_fail, input, 1, mode bit, sampled together with an accepted start. 1 = abort on the first mismatch.
- dut_in, output, N_IN, current stimulus vector.
- dut_out, input, N_OUT, DUT response, sampled synchronously.
- busy, output, 1, high while in state RUN.
- done, output, 1, high in state DONE.
- pass, output, 1, done && err_count==0.
- err_count, output, N_IN+1, number of mismatching vectors.
- fail_valid, output, 1, at least one mismatch recorded.
- fail_vec, output, N_IN, first mismatching vector.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, dut_in=0, hold_cnt=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, latched mode=0.
- States:
  - IDLE -> RUN when start=1. On that edge: vec=0, hold_cnt=0, err_count=0, fail_valid=0, fail_vec=0, mode latched from stop_on_fail.
  - RUN: dut_in=vec. hold_cnt increments every clock.
  - At hold_cnt==SAMPLE_AT: if dut_out != EXPECTED entry for vec, then err_count+1. If fail_valid==0, also set fail_valid=1 and fail_vec=vec.
  - Mismatch with latched mode=1: go to DONE on the same edge; vec is not advanced.
  - At hold_cnt==HOLD_CYCLES-1: if vec==2^N_IN-1, go to DONE. Otherwise vec+1 and hold_cnt=0.
  - DONE: done=1 and results held. dut_in keeps its last vector. start=1 restarts exactly as from IDLE, with all results cleared on the same edge.
- start while RUN: ignored, no restart and no effect on the latched mode.
- Timing: if start is accepted at edge k, a full sweep enters DONE at edge k+(2^N_IN)*HOLD_CYCLES.
- Abort timing: an abort on vector v at hold index SAMPLE_AT enters DONE at edge k + v*HOLD_CYCLES + SAMPLE_AT + 1.
- err_count maximum is 2^N_IN, so the counter cannot wrap.
- pass is combinational from the done state and err_count; it is 0 outside DONE.
- dut_in changes only on the edge that advances vec. It is registered and glitch-free.
- Reset asserted mid-sweep returns all outputs to reset values immediately (asynchronous); partial results are discarded.
- X/Z on dut_out counts as a mismatch in simulation; the bench flags it.

Decomposition:
- Package truth_sweep_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - helper function returning the table entry for vec;
  - localparam widths derived from N_IN/HOLD_CYCLES (cnt width = $clog2(HOLD_CYCLES)).
- One natural sub-module, sweep_timer, contains the vec and hold_cnt counters and emits sample_en and last_vec_end strobes.
- The top level holds the FSM, comparison, and result registers.

Test Plan:
- N_IN=4, HOLD=4, SAMPLE_AT=2, EXPECTED=16'hA5C3, DUT model matches the table -> done rises 64 clocks after start; pass=1, err_count=0, fail_valid=0; dut_in steps 0..15 every 4 clocks.
- Same config, DUT output for vector 5 and vector 11 inverted, stop_on_fail=0 -> full sweep; err_count=2, fail_vec=5, pass=0.
- Same faults, stop_on_fail=1 -> DONE 23 clocks after start (5*4+2+1); dut_in=5; err_count=1; fail_vec=5.
- rst_n pulsed low at vector 7 mid-sweep -> all outputs zero immediately; start again gives a clean full sweep with pass=1.
- start pulsed during RUN at vector 3 -> ignored, sweep completes normally. start in DONE -> results cleared, new sweep begins at vector 0.
- N_IN=2, N_OUT=2, HOLD=2, SAMPLE_AT=1, EXPECTED=8'b11_10_01_00, DUT is a passthrough -> done 8 clocks after start, pass=1.

Source files
------------

// File: rtl/truth_sweep_pkg.sv
// Shared types and helpers for the exhaustive truth-table sweeper.
// Table lookup works on a max-size table so one function serves every config.
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned MAX_IN  = 8;
  localparam int unsigned MAX_OUT = 8;
  localparam int unsigned TBL_W   = (1 << MAX_IN) * MAX_OUT;

  function automatic int unsigned cnt_width(input int unsigned hold);
    return (hold < 2) ? 1 : $clog2(hold);
  endfunction

  function automatic logic [MAX_OUT-1:0] tbl_entry(
    input logic [TBL_W-1:0] tbl,
    input int unsigned      vec,
    input int unsigned      n_out
  );
    logic [TBL_W-1:0]   sh;
    logic [MAX_OUT-1:0] mask;
    sh   = tbl >> (vec * n_out);
    mask = MAX_OUT'((1 << n_out) - 1);
    return sh[MAX_OUT-1:0] & mask;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_timer.sv
// Vector and hold counters of the sweeper.
// Strobes mark the sample point and the end of the final vector.
module sweep_timer
  import truth_sweep_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned HOLD_CYCLES = 50,
  parameter int unsigned SAMPLE_AT   = 1,
  parameter int unsigned CW          = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            run_i,
  input  logic            freeze_i,
  output logic [N_IN-1:0] vec_o,
  output logic            sample_en_o,
  output logic            last_vec_end_o
);

  localparam logic [CW-1:0]   SAMPLE_IDX = CW'(SAMPLE_AT);
  localparam logic [CW-1:0]   HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST   = '1;

  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic            hold_end, step;

  assign hold_end       = (hold_q == HOLD_LAST);
  assign step           = run_i && !freeze_i;
  assign vec_o          = vec_q;
  assign sample_en_o    = run_i && (hold_q == SAMPLE_IDX);
  assign last_vec_end_o = run_i && hold_end && (vec_q == VEC_LAST);

  always_comb begin
    vec_d  = vec_q;
    hold_d = hold_q;
    unique case (1'b1)
      clear_i: begin
        vec_d  = '0;
        hold_d = '0;
      end
      (step && hold_end && vec_q != VEC_LAST): begin
        vec_d  = vec_q + 1'b1;
        hold_d = '0;
      end
      (step && !hold_end): hold_d = hold_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      hold_q <= '0;
    end else begin
      vec_q  <= vec_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked exhaustive sweeper: drives all input vectors, compares
// sampled DUT outputs to a truth table and records the results.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned N_OUT       = 1,
  parameter int unsigned HOLD_CYCLES = 50,
  parameter int unsigned SAMPLE_AT   = 1,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_on_fail_i,
  output logic [N_IN-1:0]  dut_in_o,
  input  logic [N_OUT-1:0] dut_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [N_IN:0]    err_count_o,
  output logic             fail_valid_o,
  output logic [N_IN-1:0]  fail_vec_o
);

  localparam int unsigned CW = cnt_width(HOLD_CYCLES);

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] fvec_q, fvec_d;

  logic [TBL_W-1:0] tbl;
  logic [N_IN-1:0]  vec;
  logic [N_OUT-1:0] exp_out;
  logic             sample_en, last_end;
  logic             clear, running, mism, abort;

  assign tbl     = TBL_W'(EXPECTED);
  assign exp_out = N_OUT'(tbl_entry(tbl, 32'(vec), N_OUT));
  assign running = (state_q == RUN);
  assign clear   = start_i && !running;
  // !== so that X/Z responses count as mismatches in simulation
  assign mism    = sample_en && (dut_out_i !== exp_out);
  assign abort   = mism && mode_q;

  sweep_timer #(
    .N_IN       (N_IN),
    .HOLD_CYCLES(HOLD_CYCLES),
    .SAMPLE_AT  (SAMPLE_AT),
    .CW         (CW)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear),
    .run_i         (running),
    .freeze_i      (abort),
    .vec_o         (vec),
    .sample_en_o   (sample_en),
    .last_vec_end_o(last_end)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          mode_d  = stop_on_fail_i;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
        end
      end
      RUN: begin
        if (mism) begin
          err_d = err_q + 1'b1;
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec;
          end
        end
        if (abort || last_end) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  assign dut_in_o     = vec;
  assign busy_o       = running;
  assign done_o       = (state_q == DONE);
  assign pass_o       = done_o && (err_q == '0);
  assign err_count_o  = err_q;
  assign fail_valid_o = fv_q;
  assign fail_vec_o   = fvec_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: two configurations,
// clean sweeps, injected faults, abort, mid-sweep reset and restarts.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;

  logic       start_a, sof_a;
  logic [3:0] dut_in_a;
  logic [0:0] dut_out_a;
  logic       busy_a, done_a, pass_a, fv_a;
  logic [4:0] err_a;
  logic [3:0] fvec_a;

  logic       start_b, sof_b;
  logic [1:0] dut_in_b, dut_out_b;
  logic       busy_b, done_b, pass_b, fv_b;
  logic [2:0] err_b;
  logic [1:0] fvec_b;

  logic [15:0] tbl_a = 16'hA5C3;
  logic        fault_en;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  truth_table_sweeper #(
    .N_IN(4), .N_OUT(1), .HOLD_CYCLES(4), .SAMPLE_AT(2),
    .EXPECTED(16'hA5C3)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_a), .stop_on_fail_i(sof_a),
    .dut_in_o(dut_in_a), .dut_out_i(dut_out_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .err_count_o(err_a), .fail_valid_o(fv_a), .fail_vec_o(fvec_a)
  );

  truth_table_sweeper #(
    .N_IN(2), .N_OUT(2), .HOLD_CYCLES(2), .SAMPLE_AT(1),
    .EXPECTED(8'b11_10_01_00)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_b), .stop_on_fail_i(sof_b),
    .dut_in_o(dut_in_b), .dut_out_i(dut_out_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .err_count_o(err_b), .fail_valid_o(fv_b), .fail_vec_o(fvec_b)
  );

  always_comb begin
    dut_out_a = tbl_a[dut_in_a];
    if (fault_en && (dut_in_a == 4'd5 || dut_in_a == 4'd11))
      dut_out_a = ~tbl_a[dut_in_a];
  end

  assign dut_out_b = dut_in_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_a(input logic mode);
    @(negedge clk);
    start_a = 1'b1;
    sof_a   = mode;
    @(negedge clk);
    start_a = 1'b0;
    sof_a   = 1'b0;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    while (!done_a && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int m;
    rst_n    = 1'b0;
    start_a  = 1'b0;
    sof_a    = 1'b0;
    start_b  = 1'b0;
    sof_b    = 1'b0;
    fault_en = 1'b0;
    #12;
    chk("rst_dut_in", dut_in_a, 0);
    chk("rst_flags", {busy_a, done_a, pass_a, fv_a}, 0);
    chk("rst_err", err_a, 0);
    chk("rst_fvec", fvec_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // clean sweep: dut_in steps every 4 clocks, done after 64
    pulse_a(1'b0);
    chk("busy_after_start", busy_a, 1);
    for (int i = 0; i < 64; i++) begin
      chk("step", {done_a, dut_in_a}, {1'b0, 4'(i / 4)});
      @(negedge clk);
    end
    chk("clean_done_at_64", done_a, 1);
    chk("clean_pass", pass_a, 1);
    chk("clean_err", err_a, 0);
    chk("clean_fv", fv_a, 0);
    chk("clean_busy", busy_a, 0);
    chk("clean_last_vec", dut_in_a, 15);

    // faults at 5 and 11, continue on fail; restart from DONE
    fault_en = 1'b1;
    pulse_a(1'b0);
    chk("restart_vec0", dut_in_a, 0);
    chk("restart_done_clr", done_a, 0);
    wait_a(n);
    chk("fault_latency", n, 64);
    chk("fault_err", err_a, 2);
    chk("fault_fvec", fvec_a, 5);
    chk("fault_fv", fv_a, 1);
    chk("fault_pass", pass_a, 0);

    // stop on first fail
    pulse_a(1'b1);
    chk("restart_err_clr", err_a, 0);
    chk("restart_fv_clr", fv_a, 0);
    wait_a(n);
    chk("abort_latency", n, 23);
    chk("abort_dut_in", dut_in_a, 5);
    chk("abort_err", err_a, 1);
    chk("abort_fvec", fvec_a, 5);
    chk("abort_pass", pass_a, 0);

    // start during RUN at vector 3 must be ignored
    pulse_a(1'b0);
    repeat (13) @(negedge clk);
    chk("mid_vec3", dut_in_a, 3);
    start_a = 1'b1;
    sof_a   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    sof_a   = 1'b0;
    chk("ignored_start_vec", dut_in_a, 3);
    wait_a(m);
    chk("ignored_start_latency", 14 + m, 64);
    chk("ignored_start_err", err_a, 2);
    chk("ignored_start_fvec", fvec_a, 5);

    // asynchronous reset at vector 7
    fault_en = 1'b0;
    pulse_a(1'b0);
    repeat (29) @(negedge clk);
    chk("pre_reset_vec7", dut_in_a, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_all", {dut_in_a, busy_a, done_a, pass_a,
                          err_a, fv_a, fvec_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_a(1'b0);
    wait_a(n);
    chk("post_reset_latency", n, 64);
    chk("post_reset_pass", pass_a, 1);
    chk("post_reset_err", err_a, 0);

    // 2-in/2-out passthrough config
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_latency", n, 8);
    chk("b_pass", pass_b, 1);
    chk("b_err", err_b, 0);
    chk("b_last_vec", dut_in_b, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
